// File: rtl/h264_sched_pkg.sv
// Shared types and constants for the H.264 encode frame scheduler.
package h264_sched_pkg;

  localparam int unsigned QP_W           = 6;
  localparam int unsigned QP_MAX_LEGAL   = 51;
  localparam int unsigned DW_DEF         = 8;
  localparam int unsigned CNT_W_DEF      = 24;
  localparam int unsigned DRAIN_IDLE_DEF = 1024;
  localparam int unsigned TOL_SHIFT_DEF  = 3;
  localparam int unsigned QP_INIT_DEF    = 28;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    UPDATE = 2'd3
  } sched_state_e;

  // Clamp a one-bit-wider QP candidate into [lo, hi].
  function automatic logic [QP_W-1:0] qp_clamp(input logic [QP_W:0]   qp,
                                               input logic [QP_W-1:0] lo,
                                               input logic [QP_W-1:0] hi);
    if (qp > {1'b0, hi}) return hi;
    if (qp < {1'b0, lo}) return lo;
    return qp[QP_W-1:0];
  endfunction

endpackage

// File: rtl/h264_qp_rate_ctrl.sv
// Per-frame QP rate control: one step up/down against a dead band around the
// target frame size, clamped to the configured limits.
module h264_qp_rate_ctrl
  import h264_sched_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned TOL_SHIFT = TOL_SHIFT_DEF,
  parameter int unsigned QP_INIT   = QP_INIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             update,
  input  logic             rc_en,
  input  logic [QP_W-1:0]  qp_man,
  input  logic [QP_W-1:0]  qp_min,
  input  logic [QP_W-1:0]  qp_max,
  input  logic [CNT_W-1:0] words,
  input  logic [CNT_W-1:0] target,
  output logic [QP_W-1:0]  rc_qp
);

  logic [QP_W-1:0]  rc_qp_q, rc_qp_d;
  logic [CNT_W:0]   band, hi_lim, lo_lim, words_x;
  logic [QP_W:0]    qp_step;
  logic [QP_W-1:0]  max_eff;

  always_comb begin
    band    = (CNT_W+1)'(target >> TOL_SHIFT);
    words_x = {1'b0, words};
    hi_lim  = {1'b0, target} + band;
    lo_lim  = {1'b0, target} - band;
    if (lo_lim[CNT_W]) lo_lim = '0;
    max_eff = (qp_max > QP_W'(QP_MAX_LEGAL)) ? QP_W'(QP_MAX_LEGAL) : qp_max;

    qp_step = {1'b0, rc_qp_q};
    if (words_x > hi_lim) begin
      qp_step = {1'b0, rc_qp_q} + (QP_W+1)'(1);
    end else if ((words_x < lo_lim) && (rc_qp_q != '0)) begin
      qp_step = {1'b0, rc_qp_q} - (QP_W+1)'(1);
    end

    rc_qp_d = rc_qp_q;
    if (update) begin
      rc_qp_d = rc_en ? qp_clamp(qp_step, qp_min, max_eff) : qp_man;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rc_qp_q <= QP_W'(QP_INIT);
    else       rc_qp_q <= rc_qp_d;
  end

  assign rc_qp = rc_qp_q;

endmodule

// File: rtl/h264_encode_scheduler.sv
// Frame-level gate in front of the H.264 I-frame encoder: accepts one frame at
// a time, waits for encoder output to go quiet, then updates QP and counters.
module h264_encode_scheduler
  import h264_sched_pkg::*;
#(
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned DRAIN_IDLE = DRAIN_IDLE_DEF,
  parameter int unsigned TOL_SHIFT  = TOL_SHIFT_DEF,
  parameter int unsigned QP_INIT    = QP_INIT_DEF
) (
  input  logic             PIX_CLK,
  input  logic             RESET,
  input  logic             ENABLE_I,
  input  logic             RC_EN_I,
  input  logic [QP_W-1:0]  QP_I,
  input  logic [QP_W-1:0]  QP_MIN_I,
  input  logic [QP_W-1:0]  QP_MAX_I,
  input  logic [CNT_W-1:0] TARGET_WORDS_I,
  input  logic [15:0]      HRES_I,
  input  logic [15:0]      VRES_I,
  input  logic             FRAME_START_I,
  input  logic             FRAME_END_I,
  input  logic             DATA_VALID_I,
  input  logic [DW-1:0]    DATA_Y_I,
  input  logic [DW-1:0]    DATA_C_I,
  input  logic             ENC_DATA_VALID_I,
  output logic             ENC_FRAME_START_O,
  output logic             ENC_FRAME_END_O,
  output logic             ENC_DATA_VALID_O,
  output logic [DW-1:0]    ENC_DATA_Y_O,
  output logic [DW-1:0]    ENC_DATA_C_O,
  output logic [15:0]      ENC_HRES_O,
  output logic [15:0]      ENC_VRES_O,
  output logic [QP_W-1:0]  ENC_QP_O,
  output logic             BUSY_O,
  output logic [15:0]      FRAME_CNT_O,
  output logic [15:0]      SKIP_CNT_O,
  output logic [CNT_W-1:0] LAST_SIZE_O,
  output logic             ERR_O
);

  localparam int unsigned IDLE_W = $clog2(DRAIN_IDLE + 1);

  sched_state_e     state_q, state_d;
  logic             fs_q, fs_d, fe_q, fe_d, dv_q, dv_d, busy_q, busy_d, err_q, err_d;
  logic [DW-1:0]    y_q, y_d, c_q, c_d;
  logic [15:0]      hres_q, hres_d, vres_q, vres_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d, skip_cnt_q, skip_cnt_d;
  logic [QP_W-1:0]  qp_q, qp_d, rc_qp;
  logic [CNT_W-1:0] words_q, words_d, last_size_q, last_size_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic             count_beat;

  h264_qp_rate_ctrl #(
    .CNT_W     (CNT_W),
    .TOL_SHIFT (TOL_SHIFT),
    .QP_INIT   (QP_INIT)
  ) u_rc (
    .clk    (PIX_CLK),
    .reset  (RESET),
    .update (state_q == UPDATE),
    .rc_en  (RC_EN_I),
    .qp_man (QP_I),
    .qp_min (QP_MIN_I),
    .qp_max (QP_MAX_I),
    .words  (words_q),
    .target (TARGET_WORDS_I),
    .rc_qp  (rc_qp)
  );

  always_comb begin
    state_d     = state_q;
    fs_d        = 1'b0;
    fe_d        = 1'b0;
    dv_d        = 1'b0;
    y_d         = y_q;
    c_d         = c_q;
    hres_d      = hres_q;
    vres_d      = vres_q;
    qp_d        = qp_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    last_size_d = last_size_q;
    words_d     = words_q;
    idle_d      = idle_q;
    count_beat  = 1'b0;

    unique case (state_q)
      ARMED: begin
        if (FRAME_START_I && ENABLE_I) begin
          state_d = ACTIVE;
          fs_d    = 1'b1;
          hres_d  = HRES_I;
          vres_d  = VRES_I;
          qp_d    = RC_EN_I ? rc_qp : QP_I;
          words_d = '0;
        end
      end
      ACTIVE: begin
        count_beat = 1'b1;
        dv_d       = DATA_VALID_I;
        if (DATA_VALID_I) begin
          y_d = DATA_Y_I;
          c_d = DATA_C_I;
        end
        // A start colliding with the end is a dropped frame; a lone start is a protocol error.
        if (FRAME_END_I) begin
          fe_d    = 1'b1;
          state_d = DRAIN;
          idle_d  = '0;
          if (FRAME_START_I) skip_cnt_d = skip_cnt_q + 16'd1;
        end else if (FRAME_START_I) begin
          err_d   = 1'b1;
          fe_d    = 1'b1;
          state_d = DRAIN;
          idle_d  = '0;
        end
      end
      DRAIN: begin
        count_beat = 1'b1;
        if (FRAME_START_I) skip_cnt_d = skip_cnt_q + 16'd1;
        if (ENC_DATA_VALID_I)                        idle_d  = '0;
        else if (idle_q == IDLE_W'(DRAIN_IDLE - 1))  state_d = UPDATE;
        else                                         idle_d  = idle_q + IDLE_W'(1);
      end
      UPDATE: begin
        last_size_d = words_q;
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = ARMED;
      end
      default: state_d = ARMED;
    endcase

    if (count_beat && ENC_DATA_VALID_I && !(&words_q)) words_d = words_q + CNT_W'(1);
    busy_d = (state_d != ARMED);
  end

  always_ff @(posedge PIX_CLK) begin
    if (RESET) begin
      state_q     <= ARMED;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
      dv_q        <= 1'b0;
      y_q         <= '0;
      c_q         <= '0;
      hres_q      <= '0;
      vres_q      <= '0;
      qp_q        <= QP_W'(QP_INIT);
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      skip_cnt_q  <= '0;
      last_size_q <= '0;
      words_q     <= '0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
      dv_q        <= dv_d;
      y_q         <= y_d;
      c_q         <= c_d;
      hres_q      <= hres_d;
      vres_q      <= vres_d;
      qp_q        <= qp_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      skip_cnt_q  <= skip_cnt_d;
      last_size_q <= last_size_d;
      words_q     <= words_d;
      idle_q      <= idle_d;
    end
  end

  assign ENC_FRAME_START_O = fs_q;
  assign ENC_FRAME_END_O   = fe_q;
  assign ENC_DATA_VALID_O  = dv_q;
  assign ENC_DATA_Y_O      = y_q;
  assign ENC_DATA_C_O      = c_q;
  assign ENC_HRES_O        = hres_q;
  assign ENC_VRES_O        = vres_q;
  assign ENC_QP_O          = qp_q;
  assign BUSY_O            = busy_q;
  assign FRAME_CNT_O       = frame_cnt_q;
  assign SKIP_CNT_O        = skip_cnt_q;
  assign LAST_SIZE_O       = last_size_q;
  assign ERR_O             = err_q;

endmodule
